// File: rtl/updown_mod_counter.sv
// rtl/updown_mod_counter.sv - N-bit up/down modulo counter with load, saturate, Gray output and flags
module updown_mod_counter #(
  parameter int N   = 4,
  parameter int MOD = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic         up,
  input  logic         sat,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] q,
  output logic [N-1:0] q_gray,
  output logic         tc,
  output logic         ovf,
  output logic         load_err
);

  // The modulus may equal 2^N, which does not fit in N bits, so MAX is derived at full
  // integer width and then truncated; it becomes all ones in that case.
  localparam logic [N-1:0] MAX = N'(MOD - 1);

  logic at_max;
  logic at_zero;
  logic load_bad;

  // Boundary detection shared by the next-state logic and the terminal count.
  always_comb begin
    at_max   = (q == MAX);
    at_zero  = (q == '0);
    load_bad = (load_val > MAX);
  end

  // Zero-latency outputs derived from the current count and control inputs.
  always_comb begin
    q_gray = q ^ (q >> 1);
    tc     = en & ~load & ((up & at_max) | (~up & at_zero));
  end

  // Count register with priority load > enable > hold; flags update alongside.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q        <= '0;
      ovf      <= 1'b0;
      load_err <= 1'b0;
    end else begin
      load_err <= 1'b0;
      if (load) begin
        ovf <= 1'b0;
        if (load_bad) begin
          q        <= MAX;
          load_err <= 1'b1;
        end else begin
          q <= load_val;
        end
      end else if (en) begin
        if (up) begin
          if (at_max) begin
            ovf <= 1'b1;
            if (!sat) q <= '0;
          end else begin
            q <= q + N'(1);
          end
        end else begin
          if (at_zero) begin
            ovf <= 1'b1;
            if (!sat) q <= MAX;
          end else begin
            q <= q - N'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb/tb_updown_mod_counter.sv - table-driven scoreboard bench for updown_mod_counter
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       clr, en, up, sat, load;
  logic [3:0] load_val;
  logic [3:0] q, q_gray, q16, q_gray16;
  logic       tc, ovf, load_err, tc16, ovf16, load_err16;

  int errors = 0;
  int checks = 0;

  updown_mod_counter #(.N(4), .MOD(10)) dut (
    .clk(clk), .clr(clr), .en(en), .up(up), .sat(sat), .load(load),
    .load_val(load_val), .q(q), .q_gray(q_gray), .tc(tc), .ovf(ovf),
    .load_err(load_err)
  );

  updown_mod_counter #(.N(4), .MOD(16)) dut16 (
    .clk(clk), .clr(clr), .en(en), .up(up), .sat(sat), .load(load),
    .load_val(load_val), .q(q16), .q_gray(q_gray16), .tc(tc16), .ovf(ovf16),
    .load_err(load_err16)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en, up, sat, load;
    logic [3:0] lv;
    logic       tc;
    logic [3:0] q;
    logic       ovf, lerr;
  } vec_t;

  typedef struct {
    logic [3:0] q;
    logic       ovf, lerr;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic a_en, input logic a_up, input logic a_sat, input logic a_load,
                     input logic [3:0] a_lv, input logic a_tc, input logic [3:0] a_q,
                     input logic a_ovf, input logic a_lerr);
    vec_t v;
    v.en = a_en; v.up = a_up; v.sat = a_sat; v.load = a_load; v.lv = a_lv;
    v.tc = a_tc; v.q = a_q; v.ovf = a_ovf; v.lerr = a_lerr;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [3:0] eg;

    // Up-count with wrap from 0, MOD=10
    for (int i = 1; i <= 12; i++)
      add(1, 1, 0, 0, 0, (i == 10), 4'(i % 10), (i >= 10), 0);
    // Down from 0 wraps to MAX
    add(0, 0, 0, 1, 0,  0, 0, 0, 0);
    add(1, 0, 0, 0, 0,  1, 9, 1, 0);
    add(1, 0, 0, 0, 0,  0, 8, 1, 0);
    add(1, 0, 0, 0, 0,  0, 7, 1, 0);
    // Saturate up from 8
    add(0, 0, 0, 1, 8,  0, 8, 0, 0);
    add(1, 1, 1, 0, 0,  0, 9, 0, 0);
    add(1, 1, 1, 0, 0,  1, 9, 1, 0);
    add(1, 1, 1, 0, 0,  1, 9, 1, 0);
    add(1, 1, 1, 0, 0,  1, 9, 1, 0);
    // Out-of-range load, then load beats enable and clears ovf
    add(0, 0, 0, 1, 13, 0, 9, 0, 1);
    add(1, 1, 1, 0, 0,  1, 9, 1, 0);
    add(1, 1, 0, 1, 5,  0, 5, 0, 0);
    add(0, 0, 0, 1, 10, 0, 9, 0, 1);
    add(0, 0, 0, 1, 9,  0, 9, 0, 0);
    add(0, 1, 0, 0, 0,  0, 9, 0, 0);
    // Hold at 6 for five edges
    add(0, 0, 0, 1, 6,  0, 6, 0, 0);
    for (int i = 0; i < 5; i++)
      add(0, 1, 0, 0, 0, 0, 6, 0, 0);
    // Saturate down at 0, hold keeps ovf, count keeps ovf sticky
    add(0, 0, 0, 1, 0,  0, 0, 0, 0);
    add(1, 0, 1, 0, 0,  1, 0, 1, 0);
    add(0, 0, 0, 0, 0,  0, 0, 1, 0);
    add(1, 1, 0, 0, 0,  0, 1, 1, 0);

    clr = 1'b1; en = 1'b0; up = 1'b0; sat = 1'b0; load = 1'b0; load_val = 4'd0;
    #1;
    chk("reset_q", q, 0);
    chk("reset_gray", q_gray, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_load_err", load_err, 0);
    chk("reset_tc", tc, 0);
    @(negedge clk);
    clr = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      en = vecs[i].en; up = vecs[i].up; sat = vecs[i].sat;
      load = vecs[i].load; load_val = vecs[i].lv;
      #1;
      chk($sformatf("v%0d_tc", i), tc, vecs[i].tc);
      e.q = vecs[i].q; e.ovf = vecs[i].ovf; e.lerr = vecs[i].lerr;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      eg = e.q ^ (e.q >> 1);
      chk($sformatf("v%0d_q", i), q, e.q);
      chk($sformatf("v%0d_gray", i), q_gray, eg);
      chk($sformatf("v%0d_ovf", i), ovf, e.ovf);
      chk($sformatf("v%0d_load_err", i), load_err, e.lerr);
    end

    // Async clear mid-count with ovf set, between clock edges
    @(negedge clk);
    en = 1'b1; up = 1'b1; sat = 1'b0; load = 1'b0;
    @(posedge clk); #1;
    chk("pre_clr_q", q, 2);
    chk("pre_clr_ovf", ovf, 1);
    #2 clr = 1'b1;
    #1;
    chk("async_clr_q", q, 0);
    chk("async_clr_ovf", ovf, 0);
    chk("async_clr_gray", q_gray, 0);
    chk("async_clr_clk_high", clk, 1);
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk); #1;
    chk("post_clr_first_edge", q, 1);

    // Async clear kills a pending load_err pulse
    @(negedge clk);
    en = 1'b0; load = 1'b1; load_val = 4'd12;
    @(posedge clk); #1;
    chk("lerr_before_clr", load_err, 1);
    chk("lerr_q_max", q, 9);
    #2 clr = 1'b1;
    #1;
    chk("clr_lerr", load_err, 0);
    chk("clr_lerr_q", q, 0);
    @(negedge clk);
    clr = 1'b0; load = 1'b0;

    // Full-range modulus 2^N natural rollover
    @(negedge clk);
    load = 1'b1; load_val = 4'd15;
    @(posedge clk); #1;
    chk("m16_load_q", q16, 15);
    chk("m16_load_err", load_err16, 0);
    chk("m16_gray_15", q_gray16, 4'b1000);
    @(negedge clk);
    load = 1'b0; en = 1'b1; up = 1'b1; sat = 1'b0;
    #1;
    chk("m16_tc", tc16, 1);
    chk("m16_ovf_pre", ovf16, 0);
    @(posedge clk); #1;
    chk("m16_wrap_q", q16, 0);
    chk("m16_wrap_gray", q_gray16, 0);
    chk("m16_wrap_ovf", ovf16, 1);
    @(posedge clk); #1;
    chk("m16_next_q", q16, 1);
    chk("m16_next_gray", q_gray16, 4'b0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
